// File: rtl/window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers hold the previous rows; windows are emitted only when all nine taps are interior.
module window_gen #(
    parameter int unsigned IMG_WIDTH  = 256,
    parameter int unsigned IMG_HEIGHT = 256,
    parameter int unsigned FILT_WIDTH = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [7:0]                          pixelIn,
    input  logic                                pixValid,
    output logic [8*FILT_WIDTH*FILT_WIDTH-1:0]  FilterBuffer,
    output logic                                windowValid,
    output logic                                frameDone
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned FW    = FILT_WIDTH;
    localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(FW - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(FW - 2);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   col_d;
    logic [ROW_W-1:0]   row_q;
    logic [ROW_W-1:0]   row_d;
    logic [PIX_W-1:0]   win_q [FW][FW];
    logic [PIX_W-1:0]   win_d [FW][FW];
    logic               valid_q;
    logic               valid_d;
    logic               done_q;
    logic               done_d;

    logic [PIX_W-1:0]   lb0_q [IMG_WIDTH];
    logic [PIX_W-1:0]   lb1_q [IMG_WIDTH];

    logic               accept_c;
    logic               col_last_c;
    logic               row_last_c;
    logic [PIX_W-1:0]   top_c;
    logic [PIX_W-1:0]   mid_c;

    assign accept_c   = enable & pixValid;
    assign col_last_c = (col_q == COL_LAST);
    assign row_last_c = (row_q == ROW_LAST);
    assign top_c      = lb1_q[col_q];
    assign mid_c      = lb0_q[col_q];

    // Raster position counters, advancing only on accepted pixels.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept_c) begin
            if (col_last_c) begin
                col_d = '0;
                row_d = row_last_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Next-state: RUN once the two oldest rows are buffered, back to FILL at frame wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (accept_c && col_last_c && (row_q == ROW_FILL_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_c && col_last_c && row_last_c) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Output decode; the column gate discards windows still holding the previous row's tail.
    always_comb begin
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (accept_c) begin
            valid_d = (state_q == ST_RUN) && (col_q >= COL_FIRST_WIN);
            done_d  = col_last_c && row_last_c;
        end
    end

    // Window shifts left; the new right column is {older row, previous row, incoming pixel}.
    always_comb begin
        win_d = win_q;
        if (accept_c) begin
            for (int unsigned r = 0; r < FW; r++) begin
                for (int unsigned c = 0; c + 1 < FW; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][FW-1] = top_c;
            win_d[1][FW-1] = mid_c;
            win_d[2][FW-1] = pixelIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '{default: '0};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Line buffers are not reset; rows 0 and 1 of every frame overwrite them before use.
    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            lb1_q[col_q] <= mid_c;
            lb0_q[col_q] <= pixelIn;
        end
    end

    // Slot k = (FW-1-r)*FW + (FW-1-c): top-left lands in the MSB slot, newest pixel in slot 0.
    for (genvar r = 0; r < FW; r++) begin : g_pack_row
        for (genvar c = 0; c < FW; c++) begin : g_pack_col
            assign FilterBuffer[PIX_W*((FW-1-r)*FW + (FW-1-c)) +: PIX_W] = win_q[r][c];
        end
    end

    assign windowValid = valid_q;
    assign frameDone   = done_q;

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on a 4x4 image; expected windows queue up as pixels are driven
// and are matched cycle-accurately against the DUT outputs.
module tb_window_gen;

    localparam int unsigned W = 4;
    localparam int unsigned H = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  pixelIn;
    logic        pixValid;
    logic [71:0] FilterBuffer;
    logic        windowValid;
    logic        frameDone;

    window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FILT_WIDTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pixelIn      (pixelIn),
        .pixValid     (pixValid),
        .FilterBuffer (FilterBuffer),
        .windowValid  (windowValid),
        .frameDone    (frameDone)
    );

    typedef struct {
        logic [71:0] win;
        logic        done;
        int unsigned stamp;
    } exp_t;

    exp_t        sb[$];
    logic [71:0] wins_seen[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          brow = 0;
    int          bcol = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int wr = 0; wr < 3; wr++) begin
            for (int wc = 0; wc < 3; wc++) begin
                w[8*((2-wr)*3 + (2-wc)) +: 8] = 8'(base + (r-2+wr)*16 + (c-2+wc));
            end
        end
        return w;
    endfunction

    // Per-cycle output monitor: a pulse must appear exactly in the cycle the scoreboard predicts.
    always @(negedge clk) begin : mon
        logic exp_v;
        exp_t e;
        exp_v = (sb.size() > 0) && (sb[0].stamp == cyc);
        chk("windowValid", 72'(windowValid), 72'(exp_v));
        if (exp_v) begin
            e = sb.pop_front();
            chk("frameDone", 72'(frameDone), 72'(e.done));
            chk("window", FilterBuffer, e.win);
        end else begin
            chk("frameDone_idle", 72'(frameDone), 72'(1'b0));
        end
        if (windowValid === 1'b1) wins_seen.push_back(FilterBuffer);
    end

    task automatic cyc_drive(input logic e, input logic v, input logic r, input logic [7:0] p);
        enable   = e;
        pixValid = v;
        rst      = r;
        pixelIn  = p;
        @(negedge clk);
    endtask

    task automatic send_pix(input int base);
        exp_t e;
        logic [7:0] p;
        p = 8'(base + brow*16 + bcol);
        if (brow >= 2 && bcol >= 2) begin
            e.win   = exp_win(base, brow, bcol);
            e.done  = (brow == H-1) && (bcol == W-1);
            e.stamp = cyc + 1;
            sb.push_back(e);
        end
        cyc_drive(1'b1, 1'b1, 1'b0, p);
        if (bcol == W-1) begin
            bcol = 0;
            brow = (brow == H-1) ? 0 : brow + 1;
        end else begin
            bcol = bcol + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b1, 1'b0, 1'b0, 8'hEE);
    endtask

    initial begin
        logic [71:0] w;
        enable = 1'b0; pixValid = 1'b0; rst = 1'b1; pixelIn = 8'h00;
        @(negedge clk);

        // Reset state
        cyc_drive(1'b0, 1'b0, 1'b1, 8'h00);
        chk("rst_window", FilterBuffer, 72'h0);
        chk("rst_valid", 72'(windowValid), 72'h0);
        chk("rst_done", 72'(frameDone), 72'h0);
        chk("rst_col", 72'(dut.col_q), 72'h0);
        chk("rst_row", 72'(dut.row_q), 72'h0);

        // Two back-to-back frames, second offset by 0x80
        idle(1);
        for (int i = 0; i < W*H; i++) send_pix(0);
        for (int i = 0; i < W*H; i++) send_pix(8'h80);
        idle(2);
        chk("b2b_count", 72'(wins_seen.size()), 72'd8);
        if (wins_seen.size() == 8) begin
            chk("f1_first", wins_seen[0], 72'h000102101112202122);
            chk("f1_last", wins_seen[3], 72'h111213212223313233);
            w = wins_seen[4];
            chk("f2_first_tl", 72'(w[71:64]), 72'h80);
            chk("f2_first", w, 72'h808182909192A0A1A2);
        end
        chk("b2b_sb_empty", 72'(sb.size()), 72'd0);
        wins_seen.delete();

        // Random pixValid gaps plus enable low for 5 cycles mid-row
        for (int i = 0; i < W*H; i++) begin
            if (i == 9) repeat (5) cyc_drive(1'b0, 1'b1, 1'b0, 8'hFF);
            send_pix(0);
            if ((i % 3) != 2) idle(int'($urandom_range(1, 3)));
        end
        idle(2);
        chk("gap_count", 72'(wins_seen.size()), 72'd4);
        if (wins_seen.size() == 4) begin
            chk("gap_first", wins_seen[0], 72'h000102101112202122);
            chk("gap_last", wins_seen[3], 72'h111213212223313233);
        end
        chk("gap_sb_empty", 72'(sb.size()), 72'd0);
        wins_seen.delete();

        // Reset mid-frame after pixel 0x21 with a pixel presented on the reset edge
        for (int i = 0; i < 10; i++) send_pix(0);
        cyc_drive(1'b1, 1'b1, 1'b1, 8'h22);
        chk("midrst_window", FilterBuffer, 72'h0);
        chk("midrst_valid", 72'(windowValid), 72'h0);
        chk("midrst_done", 72'(frameDone), 72'h0);
        chk("midrst_col", 72'(dut.col_q), 72'h0);
        chk("midrst_row", 72'(dut.row_q), 72'h0);
        brow = 0;
        bcol = 0;
        for (int i = 0; i < W*H; i++) send_pix(0);
        idle(2);
        chk("rst_frame_count", 72'(wins_seen.size()), 72'd4);
        if (wins_seen.size() == 4) chk("rst_frame_first", wins_seen[0], 72'h000102101112202122);
        wins_seen.delete();

        // pixValid high with enable low for a full row: position must hold
        for (int i = 0; i < 6; i++) send_pix(8'h40);
        for (int i = 0; i < W; i++) cyc_drive(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        chk("hold_col", 72'(dut.col_q), 72'd2);
        chk("hold_row", 72'(dut.row_q), 72'd1);
        for (int i = 6; i < W*H; i++) send_pix(8'h40);
        idle(2);
        chk("hold_count", 72'(wins_seen.size()), 72'd4);
        if (wins_seen.size() == 4) chk("hold_first", wins_seen[0], 72'h404142505152606162);
        chk("hold_sb_empty", 72'(sb.size()), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
